// File: rtl/repetition_pkg.sv
// Shared types for the repetition matcher: operator encoding, per-channel config and legality.
package repetition_pkg;

  localparam int unsigned REP_CNT_W = 8;
  localparam int unsigned REP_WIN_W = 12;

  // Encoding 2'd3 is reserved and rejected at trigger time.
  typedef enum logic [1:0] {
    REP_CONSEC    = 2'd0,
    REP_GOTO      = 2'd1,
    REP_NONCONSEC = 2'd2
  } rep_mode_e;

  typedef struct packed {
    rep_mode_e              mode;
    logic [REP_CNT_W-1:0]   min;
    logic [REP_CNT_W-1:0]   max;
    logic [REP_WIN_W-1:0]   win;
  } channel_cfg_t;

  function automatic logic cfg_legal(channel_cfg_t cfg);
    logic known_mode;
    logic windowed;
    known_mode = (cfg.mode == REP_CONSEC) || (cfg.mode == REP_GOTO) ||
                 (cfg.mode == REP_NONCONSEC);
    windowed   = (cfg.mode == REP_GOTO) || (cfg.mode == REP_NONCONSEC);
    return known_mode && (cfg.min != '0) && (cfg.max >= cfg.min) &&
           !(windowed && (cfg.win == '0));
  endfunction

endpackage

// File: rtl/repetition_matcher_if.sv
// Flat multi-channel bundle between a stimulus source and the repetition matcher.
interface repetition_matcher_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WIN_W  = 12
);
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH-1:0]       ev;
    logic [2*NUM_CH-1:0]     cfg_mode;
    logic [CNT_W*NUM_CH-1:0] cfg_min;
    logic [CNT_W*NUM_CH-1:0] cfg_max;
    logic [WIN_W*NUM_CH-1:0] cfg_win;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       match;
    logic [NUM_CH-1:0]       fail;
    logic [NUM_CH-1:0]       cfg_err;
    logic [NUM_CH-1:0]       retrig_drop;
    logic [CNT_W*NUM_CH-1:0] count;

    modport master (
        output trig, ev, cfg_mode, cfg_min, cfg_max, cfg_win,
        input  busy, match, fail, cfg_err, retrig_drop, count
    );

    modport slave (
        input  trig, ev, cfg_mode, cfg_min, cfg_max, cfg_win,
        output busy, match, fail, cfg_err, retrig_drop, count
    );
endinterface

// File: rtl/repetition_channel.sv
// One independent "trig ##1 ev[op min:max]" detector with latched config and registered results.
module repetition_channel
    import repetition_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig_i,
    input  logic                 ev_i,
    input  channel_cfg_t         cfg_i,
    output logic                 busy_o,
    output logic                 match_o,
    output logic                 fail_o,
    output logic                 cfg_err_o,
    output logic                 retrig_drop_o,
    output logic [REP_CNT_W-1:0] count_o
);
    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e               st_q, st_d;
    channel_cfg_t         cfg_q, cfg_d;
    logic [REP_CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_WIN_W-1:0] win_q, win_d;
    logic                 match_q, match_d, fail_q, fail_d;
    logic                 err_q, err_d, drop_q, drop_d;

    logic [REP_CNT_W:0]   k_next, min_ext, max_ext;
    logic                 win_end;

    assign k_next  = {1'b0, cnt_q} + {{REP_CNT_W{1'b0}}, ev_i};
    assign min_ext = {1'b0, cfg_q.min};
    assign max_ext = {1'b0, cfg_q.max};
    // win_q counts evaluation cycles already completed, so this one is number win_q + 1.
    assign win_end = ((win_q + 1'b1) == cfg_q.win);

    always_comb begin
        st_d    = st_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        match_d = 1'b0;
        fail_d  = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        unique case (st_q)
            StIdle: begin
                cnt_d = '0;
                win_d = '0;
                if (trig_i) begin
                    if (cfg_legal(cfg_i)) begin
                        st_d  = StArmed;
                        cfg_d = cfg_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StArmed: begin
                drop_d = trig_i;
                cnt_d  = k_next[REP_CNT_W-1:0];
                if (win_q != cfg_q.win) win_d = win_q + 1'b1;
                unique case (cfg_q.mode)
                    REP_CONSEC: begin
                        if (ev_i) begin
                            match_d = (k_next >= min_ext);
                            if (k_next == max_ext) st_d = StIdle;
                        end else begin
                            fail_d = (cnt_q < cfg_q.min);
                            st_d   = StIdle;
                        end
                    end
                    REP_GOTO: begin
                        match_d = ev_i && (k_next >= min_ext);
                        if (ev_i && (k_next == max_ext)) begin
                            st_d = StIdle;
                        end else if (win_end) begin
                            fail_d = (k_next < min_ext);
                            st_d   = StIdle;
                        end
                    end
                    REP_NONCONSEC: begin
                        if (ev_i && (k_next > max_ext)) begin
                            fail_d = 1'b1;
                            cnt_d  = cfg_q.max;
                            st_d   = StIdle;
                        end else begin
                            match_d = (k_next >= min_ext);
                            if (win_end) begin
                                fail_d = (k_next < min_ext);
                                st_d   = StIdle;
                            end
                        end
                    end
                    default: st_d = StIdle;
                endcase
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            cfg_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            match_q <= match_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign busy_o        = (st_q == StArmed);
    assign match_o       = match_q;
    assign fail_o        = fail_q;
    assign cfg_err_o     = err_q;
    assign retrig_drop_o = drop_q;
    assign count_o       = cnt_q;

endmodule

// File: rtl/repetition_matcher.sv
// Multi-channel repetition detector: one repetition_channel per lane, flat bus sliced per channel.
module repetition_matcher
    import repetition_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = REP_CNT_W,
    parameter int unsigned WIN_W  = REP_WIN_W
) (
    input logic            clk,
    input logic            rst,
    repetition_matcher_if.slave bus
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        channel_cfg_t cfg;

        assign cfg.mode = rep_mode_e'(bus.cfg_mode[2*i +: 2]);
        assign cfg.min  = bus.cfg_min[CNT_W*i +: CNT_W];
        assign cfg.max  = bus.cfg_max[CNT_W*i +: CNT_W];
        assign cfg.win  = bus.cfg_win[WIN_W*i +: WIN_W];

        repetition_channel u_channel (
            .clk          (clk),
            .rst          (rst),
            .trig_i       (bus.trig[i]),
            .ev_i         (bus.ev[i]),
            .cfg_i        (cfg),
            .busy_o       (bus.busy[i]),
            .match_o      (bus.match[i]),
            .fail_o       (bus.fail[i]),
            .cfg_err_o    (bus.cfg_err[i]),
            .retrig_drop_o(bus.retrig_drop[i]),
            .count_o      (bus.count[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_repetition_matcher.sv
// Directed and randomized bench for repetition_matcher against a cycle-level behavioural model.
module tb_repetition_matcher;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int WIN_W  = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    repetition_matcher_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    repetition_matcher #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus per channel
    bit       t_trig [NUM_CH];
    bit       t_ev   [NUM_CH];
    bit [1:0] t_mode [NUM_CH];
    bit [7:0] t_min  [NUM_CH];
    bit [7:0] t_max  [NUM_CH];
    bit [11:0] t_win [NUM_CH];

    // Reference model state and expected outputs
    bit m_armed [NUM_CH];
    int m_mode [NUM_CH], m_min [NUM_CH], m_max [NUM_CH], m_win [NUM_CH];
    int m_k [NUM_CH], m_n [NUM_CH];
    bit e_busy [NUM_CH], e_match [NUM_CH], e_fail [NUM_CH], e_err [NUM_CH], e_drop [NUM_CH];
    int e_cnt [NUM_CH];

    task automatic drive();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.trig[c] = t_trig[c];
            bus.ev[c]   = t_ev[c];
            bus.cfg_mode[2*c +: 2]       = t_mode[c];
            bus.cfg_min[CNT_W*c +: CNT_W] = t_min[c];
            bus.cfg_max[CNT_W*c +: CNT_W] = t_max[c];
            bus.cfg_win[WIN_W*c +: WIN_W] = t_win[c];
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            e_match[c] = 0; e_fail[c] = 0; e_err[c] = 0; e_drop[c] = 0;
            if (rst) begin
                m_armed[c] = 0; m_k[c] = 0; e_cnt[c] = 0;
            end else if (!m_armed[c]) begin
                e_cnt[c] = 0;
                if (t_trig[c]) begin
                    if (t_mode[c] == 3 || t_min[c] == 0 || t_max[c] < t_min[c] ||
                        (t_mode[c] != 0 && t_win[c] == 0)) begin
                        e_err[c] = 1;
                    end else begin
                        m_armed[c] = 1;
                        m_mode[c] = t_mode[c]; m_min[c] = t_min[c];
                        m_max[c] = t_max[c];   m_win[c] = t_win[c];
                        m_k[c] = 0; m_n[c] = 0;
                    end
                end
            end else begin
                int  kp;
                bit  done;
                done = 0;
                e_drop[c] = t_trig[c];
                m_n[c]++;
                kp = m_k[c] + int'(t_ev[c]);
                case (m_mode[c])
                    0: begin
                        if (t_ev[c]) begin
                            e_match[c] = (kp >= m_min[c]);
                            done = (kp == m_max[c]);
                        end else begin
                            e_fail[c] = (m_k[c] < m_min[c]);
                            done = 1;
                        end
                    end
                    1: begin
                        e_match[c] = t_ev[c] && (kp >= m_min[c]);
                        if (t_ev[c] && kp == m_max[c]) done = 1;
                        else if (m_n[c] == m_win[c]) begin
                            e_fail[c] = (kp < m_min[c]);
                            done = 1;
                        end
                    end
                    default: begin
                        if (t_ev[c] && kp > m_max[c]) begin
                            e_fail[c] = 1; kp = m_max[c]; done = 1;
                        end else begin
                            e_match[c] = (kp >= m_min[c]);
                            if (m_n[c] == m_win[c]) begin
                                e_fail[c] = (kp < m_min[c]);
                                done = 1;
                            end
                        end
                    end
                endcase
                m_k[c] = kp;
                e_cnt[c] = kp;
                if (done) m_armed[c] = 0;
            end
            e_busy[c] = m_armed[c];
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            check_val($sformatf("busy[%0d]", c),  32'(bus.busy[c]),  32'(e_busy[c]));
            check_val($sformatf("match[%0d]", c), 32'(bus.match[c]), 32'(e_match[c]));
            check_val($sformatf("fail[%0d]", c),  32'(bus.fail[c]),  32'(e_fail[c]));
            check_val($sformatf("cfg_err[%0d]", c), 32'(bus.cfg_err[c]), 32'(e_err[c]));
            check_val($sformatf("retrig_drop[%0d]", c), 32'(bus.retrig_drop[c]),
                      32'(e_drop[c]));
            check_val($sformatf("count[%0d]", c), 32'(bus.count[CNT_W*c +: CNT_W]),
                      32'(e_cnt[c]));
        end
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Directed scenario machinery: per-channel trigger/event masks indexed by cycle
    logic [31:0] sc_trig [NUM_CH], sc_ev [NUM_CH];
    logic [31:0] sc_rst;
    logic [31:0] h_match [NUM_CH], h_fail [NUM_CH], h_busy [NUM_CH];
    logic [31:0] h_err [NUM_CH], h_drop [NUM_CH];
    int          h_count [NUM_CH][32];

    task automatic clear_sc();
        sc_rst = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sc_trig[c] = '0; sc_ev[c] = '0;
        end
    endtask

    task automatic setup(input int ch, input int mode, input int mn, input int mx, input int w,
                         input logic [31:0] trigm, input logic [31:0] evm);
        t_mode[ch] = 2'(mode); t_min[ch] = 8'(mn); t_max[ch] = 8'(mx); t_win[ch] = 12'(w);
        sc_trig[ch] = trigm; sc_ev[ch] = evm;
    endtask

    task automatic run_sc(input int ncyc);
        for (int c = 0; c < NUM_CH; c++) begin
            t_trig[c] = 0; t_ev[c] = 0;
            h_match[c] = '0; h_fail[c] = '0; h_busy[c] = '0; h_err[c] = '0; h_drop[c] = '0;
        end
        repeat (16) tick();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            rst = sc_rst[cyc];
            for (int c = 0; c < NUM_CH; c++) begin
                t_trig[c] = sc_trig[c][cyc];
                t_ev[c]   = sc_ev[c][cyc];
            end
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                h_match[c][cyc+1] = bus.match[c];
                h_fail[c][cyc+1]  = bus.fail[c];
                h_busy[c][cyc+1]  = bus.busy[c];
                h_err[c][cyc+1]   = bus.cfg_err[c];
                h_drop[c][cyc+1]  = bus.retrig_drop[c];
                h_count[c][cyc+1] = int'(bus.count[CNT_W*c +: CNT_W]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            t_trig[c] = 0; t_ev[c] = 0;
        end
    endtask

    logic [31:0] solo_m1, solo_f1, solo_m2, solo_f2;

    initial begin
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            t_trig[c] = 0; t_ev[c] = 0; t_mode[c] = 0; t_min[c] = 1; t_max[c] = 1; t_win[c] = 1;
            m_armed[c] = 0;
        end
        tick();
        tick();
        check_val("reset_busy", 32'(bus.busy), 32'h0);
        check_val("reset_count", 32'(bus.count), 32'h0);
        rst = 1'b0;

        // CONSEC 3..5 with a long run of events
        clear_sc(); setup(0, 0, 3, 5, 0, 32'h1, 32'h7E); run_sc(9);
        check_val("consec_match", h_match[0], 32'h70);
        check_val("consec_fail", h_fail[0], 32'h0);
        check_val("consec_busy", h_busy[0], 32'h3E);
        check_val("consec_count6", 32'(h_count[0][6]), 32'd5);

        // CONSEC 3..3 broken early
        clear_sc(); setup(1, 0, 3, 3, 0, 32'h1, 32'h6); run_sc(7);
        check_val("consec_brk_fail", h_fail[1], 32'h10);
        check_val("consec_brk_match", h_match[1], 32'h0);
        check_val("consec_brk_busy", h_busy[1], 32'hE);

        // GOTO 2..2 within window, then too few events
        clear_sc(); setup(2, 1, 2, 2, 10, 32'h1, 32'h88); run_sc(12);
        check_val("goto_match", h_match[2], 32'h100);
        check_val("goto_busy", h_busy[2], 32'hFE);
        clear_sc(); setup(2, 1, 2, 2, 10, 32'h1, 32'h8); run_sc(14);
        check_val("goto_tmo_fail", h_fail[2], 32'h800);
        check_val("goto_tmo_busy", h_busy[2], 32'h7FE);

        // NONCONSEC overshoot
        clear_sc(); setup(3, 2, 1, 2, 6, 32'h1, 32'h34); run_sc(12);
        check_val("nc_match", h_match[3], 32'h38);
        check_val("nc_fail", h_fail[3], 32'h40);
        check_val("nc_count6", 32'(h_count[3][6]), 32'd2);

        // Illegal config, then retrigger while armed
        clear_sc(); setup(0, 3, 1, 1, 1, 32'h1, 32'h0); run_sc(4);
        check_val("cfg_err", h_err[0], 32'h2);
        check_val("cfg_err_busy", h_busy[0], 32'h0);
        clear_sc(); setup(0, 1, 2, 2, 10, 32'hA0, 32'h600); run_sc(18);
        check_val("retrig_drop", h_drop[0], 32'h100);
        check_val("retrig_match", h_match[0], 32'h800);

        // Reset mid-sequence
        clear_sc(); setup(0, 1, 2, 2, 10, 32'h1, 32'h4); sc_rst = 32'h10; run_sc(8);
        check_val("rst_busy", h_busy[0], 32'h1E);
        check_val("rst_fail", h_fail[0], 32'h0);

        // Independence: solo runs versus a concurrent run
        clear_sc(); setup(1, 0, 2, 4, 0, 32'h1, 32'h1E); run_sc(12);
        solo_m1 = h_match[1]; solo_f1 = h_fail[1];
        clear_sc(); setup(2, 2, 2, 3, 8, 32'h1, 32'h52); run_sc(12);
        solo_m2 = h_match[2]; solo_f2 = h_fail[2];
        clear_sc(); setup(1, 0, 2, 4, 0, 32'h1, 32'h1E); setup(2, 2, 2, 3, 8, 32'h1, 32'h52);
        run_sc(12);
        check_val("indep_m1", h_match[1], solo_m1);
        check_val("indep_f1", h_fail[1], solo_f1);
        check_val("indep_m2", h_match[2], solo_m2);
        check_val("indep_f2", h_fail[2], solo_f2);

        // Randomized traffic with live config churn
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                int mn, mx, md;
                md = $urandom_range(0, 7);
                t_mode[c] = (md > 3) ? 2'($urandom_range(0, 2)) : 2'(md);
                mn = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
                mx = mn + $urandom_range(0, 3) - (($urandom_range(0, 9) == 0) ? 1 : 0);
                t_min[c]  = 8'(mn);
                t_max[c]  = 8'(mx);
                t_win[c]  = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 12));
                t_trig[c] = ($urandom_range(0, 5) == 0);
                t_ev[c]   = ($urandom_range(0, 1) == 1);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/repetition_matcher.md
Name: repetition_matcher

Overview:
- Synthesisable, multi-channel repetition detector for sequences of the form "trig ##1 ev[op min:max]".
- op is runtime-selectable: consecutive [*], goto [->] or non-consecutive [=].
- Per-channel count range and observation window; registered match/fail pulses.
- Used as an RTL checker/cover helper in benches and formal harnesses where SVA is unavailable or counts must be observable.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 8, width of repetition counts (min/max/count).
- WIN_W, 12, width of the window length.

Ports:
- clk  input  1  clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- trig  input  NUM_CH  per-channel sequence start.
- ev  input  NUM_CH  per-channel repeated event.
- cfg_mode  input  2*NUM_CH  per-channel rep_mode_e.
- cfg_min  input  CNT_W*NUM_CH  minimum repetitions, must be >= 1.
- cfg_max  input  CNT_W*NUM_CH  maximum repetitions, must be >= cfg_min.
- cfg_win  input  WIN_W*NUM_CH  window in cycles for GOTO/NONCONSEC, must be >= 1.
- busy  output  NUM_CH  channel armed.
- match  output  NUM_CH  1-cycle pulse: sequence matched.
- fail  output  NUM_CH  1-cycle pulse: sequence failed.
- cfg_err  output  NUM_CH  1-cycle pulse: trigger rejected because of illegal config.
- retrig_drop  output  NUM_CH  1-cycle pulse: trigger ignored while busy.
- count  output  CNT_W*NUM_CH  current repetition count; 0 when idle.

Behaviour:
- Reset: all channels IDLE; busy, match, fail, cfg_err, retrig_drop and count all 0. Reset mid-sequence abandons it with no fail pulse.
- Per-channel FSM has two states, IDLE and ARMED.
- IDLE + trig at cycle t:
  - Config legal: latch mode/min/max/win into the channel, clear count and window counter, go ARMED. busy=1 from t+1.
  - Config illegal (mode==3, min==0, max<min, or win==0 for GOTO/NONCONSEC): stay IDLE, cfg_err=1 at t+1.
- ARMED + trig: trig ignored, retrig_drop=1 in the next cycle. Live config changes while ARMED have no effect.
- Evaluation cycles are t+1, t+2, … (##1 semantics). In each evaluation cycle, k is the count before the cycle and k' = k + ev.
- Results are registered: match/fail appear the cycle after the evaluation cycle. count shows k' in the cycle after the evaluation cycle.
- CONSEC:
  - ev=1: if k' >= min, match. If k' == max, go IDLE.
  - ev=0: if k < min, fail. Go IDLE in either case.
  - Window is ignored.
- GOTO:
  - ev=1: if k' >= min, match. If k' == max, go IDLE.
  - Evaluation cycle number == win and channel not yet ended: if k' < min, fail. Go IDLE.
- NONCONSEC:
  - ev=1 with k' > max: fail, go IDLE; count holds max.
  - Otherwise, if k' >= min, match in every evaluation cycle, with or without ev.
  - At window end: if k' < min, fail. Go IDLE.
- Same-cycle ordering: ev is counted before the window-end check, so a final ev on the last window cycle can produce match. match and fail are never both high.
- Trigger on the cycle a channel returns to IDLE: trig is sampled while still ARMED, so it is dropped. A trig in the following cycle is accepted.
- Counter width: k' never exceeds max ≤ 2^CNT_W − 1, so there is no wrap. The window counter is WIN_W bits and saturates at win.
- Channels are fully independent. No cross-channel arbitration.

Decomposition:
- Package repetition_pkg:
  - typedef enum logic [1:0] rep_mode_e {REP_CONSEC=0, REP_GOTO=1, REP_NONCONSEC=2}; value 3 is reserved and illegal.
  - typedef struct packed channel_cfg_t {mode, min, max, win}, parameterised via package-level default widths.
- Sub-module repetition_channel: one FSM, latched config, count and window counter. The top is a generate loop over NUM_CH plus port slicing.

Test Plan:
- CONSEC, min=3, max=5, trig@0, ev=1 cycles 1–6 -> match at 4, 5, 6; busy low from 6; count=5 at 6; no fail.
- CONSEC, min=3, max=3, trig@0, ev=1 cycles 1–2, ev=0 at 3 -> fail at 4; no match; busy low at 4.
- GOTO, min=2, max=2, win=10, trig@0, ev at 3 and 7 -> match at 8 only; busy low at 8. Repeat with a single ev at 3 -> fail at 11.
- NONCONSEC, min=1, max=2, win=6, trig@0, ev at 2, 4, 5 -> match at 3, 4, 5; fail at 6 (k'=3 > max); no further pulses.
- Config/retrigger: mode=3 trig@0 -> cfg_err at 1, busy stays 0. Legal GOTO trig@5 then trig@7 -> retrig_drop at 8, original sequence unaffected.
- Reset mid-run and channel independence:
  - ch0 GOTO armed, rst at cycle 4 -> all outputs 0 at 5, no fail.
  - ch1 and ch2 run different modes concurrently -> results identical to each channel run alone.
